// File: rtl/uart_frame_controller_pkg.sv
// Shared definitions for the UART host-access frame controller: state encoding,
// command codes and default protocol byte values.
package uart_frame_defs;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
    localparam logic [7:0]  DEF_ACK_BYTE       = 8'h06;
    localparam logic [7:0]  DEF_NAK_BYTE       = 8'h15;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd2000000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ADDR_H,
        ST_GET_ADDR_L,
        ST_GET_LEN,
        ST_WR_RX,
        ST_WR_MEM,
        ST_RD_MEM,
        ST_SEND,
        ST_TX_WAIT
    } state_t;

    // Where TX_WAIT hands control back once the response byte has gone out.
    typedef enum logic {
        RET_IDLE,
        RET_READ
    } ret_t;

    // LEN byte 0 encodes a 256-byte transfer.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return {(len == 8'd0), len};
    endfunction

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Resettable inter-byte interval counter: counts enabled cycles since the last
// clear and flags the cycle in which the limit is reached.
module uart_frame_timeout #(
    parameter logic [31:0] LIMIT = 32'd2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Saturate at LIMIT so a stalled enable never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (count_q >= (LIMIT - 32'd1));

endmodule

// File: rtl/uart_frame_controller.sv
// Parses SYNC/CMD/ADDR/LEN command frames from uart_core and turns them into
// byte-wide memory reads and writes, answering with data, ACK or NAK.
module uart_frame_controller
    import uart_frame_defs::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data_out,
    input  logic        tx_busy,
    output logic        tx_start_transmission,
    output logic [7:0]  tx_data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        frame_error,
    output logic        overrun,
    output state_t      dbg_state_o
);

    state_t      state_q;
    ret_t        ret_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        req_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [1:0]  wait_q;
    logic [8:0]  count_q;
    logic        overrun_q;
    logic        frame_error_q;

    logic waiting_rx;
    logic drops_rx;
    logic tmo_clear;
    logic tmo_expired;

    assign waiting_rx = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR_H) ||
                        (state_q == ST_GET_ADDR_L) || (state_q == ST_GET_LEN) ||
                        (state_q == ST_WR_RX);
    assign drops_rx   = (state_q == ST_WR_MEM) || (state_q == ST_RD_MEM) ||
                        (state_q == ST_SEND) || (state_q == ST_TX_WAIT);

    // Holding the counter clear outside the byte-waiting states is what makes
    // every entry into a waiting state start from zero.
    assign tmo_clear = rx_done_tick || !waiting_rx;

    uart_frame_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (tmo_clear),
        .enable_i (waiting_rx),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ret_q         <= RET_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            req_q         <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            wait_q        <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            tx_start_q    <= 1'b0;
            frame_error_q <= 1'b0;
            if (rx_done_tick && drops_rx) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rx_done_tick && (rx_data_out == SYNC_BYTE)) begin
                        overrun_q <= 1'b0;
                        state_q   <= ST_GET_CMD;
                    end
                end
                ST_GET_CMD: begin
                    if (tmo_expired) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (rx_done_tick) begin
                        if (is_valid_cmd(rx_data_out)) begin
                            we_q    <= (rx_data_out == CMD_WRITE);
                            state_q <= ST_GET_ADDR_H;
                        end else begin
                            tx_data_q <= NAK_BYTE;
                            ret_q     <= RET_IDLE;
                            state_q   <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR_H: begin
                    if (tmo_expired) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (rx_done_tick) begin
                        addr_q[15:8] <= rx_data_out;
                        state_q      <= ST_GET_ADDR_L;
                    end
                end
                ST_GET_ADDR_L: begin
                    if (tmo_expired) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (rx_done_tick) begin
                        addr_q[7:0] <= rx_data_out;
                        state_q     <= ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    if (tmo_expired) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (rx_done_tick) begin
                        count_q <= len_to_count(rx_data_out);
                        if (we_q) begin
                            state_q <= ST_WR_RX;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= ST_RD_MEM;
                        end
                    end
                end
                ST_WR_RX: begin
                    if (tmo_expired) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (rx_done_tick) begin
                        wdata_q <= rx_data_out;
                        req_q   <= 1'b1;
                        state_q <= ST_WR_MEM;
                    end
                end
                ST_WR_MEM: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr_q + 16'd1;
                        count_q <= count_q - 9'd1;
                        if (count_q == 9'd1) begin
                            tx_data_q <= ACK_BYTE;
                            ret_q     <= RET_IDLE;
                            state_q   <= ST_SEND;
                        end else begin
                            state_q <= ST_WR_RX;
                        end
                    end
                end
                ST_RD_MEM: begin
                    if (mem_ack) begin
                        req_q     <= 1'b0;
                        tx_data_q <= mem_rdata;
                        ret_q     <= RET_READ;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        wait_q     <= 2'd2;
                        state_q    <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    // uart_core raises tx_busy a little after the start pulse,
                    // so the first cycles after it are not trusted.
                    if (wait_q != 2'd0) begin
                        wait_q <= wait_q - 2'd1;
                    end else if (!tx_busy) begin
                        if (ret_q == RET_READ) begin
                            addr_q  <= addr_q + 16'd1;
                            count_q <= count_q - 9'd1;
                            if (count_q == 9'd1) begin
                                state_q <= ST_IDLE;
                            end else begin
                                req_q   <= 1'b1;
                                state_q <= ST_RD_MEM;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start_transmission = tx_start_q;
    assign tx_data_in            = tx_data_q;
    assign mem_req               = req_q;
    assign mem_we                = we_q;
    assign mem_addr              = addr_q;
    assign mem_wdata             = wdata_q;
    assign busy                  = (state_q != ST_IDLE);
    assign frame_error           = frame_error_q;
    assign overrun               = overrun_q;
    assign dbg_state_o           = state_q;

endmodule

// File: doc/uart_frame_controller.md
Name: uart_frame_controller

Overview:
- Sequences uart_core: parses command frames arriving on the UART receive side and issues byte-wide memory requests.
- Returns read data or an acknowledgement through the UART transmit side.
- Sits between uart_core and the memory-controller user port; it is the host-access path for loading and inspecting memory.

Parameters:
- TIMEOUT_CYCLES, 32'd2000000, maximum clk cycles allowed between consecutive received bytes of one frame (20 ms at 100 MHz).
- SYNC_BYTE, 8'hA5, frame start marker.
- ACK_BYTE, 8'h06, write-complete response.
- NAK_BYTE, 8'h15, bad-command response.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_done_tick  in  1  one-cycle pulse from uart_core: rx_data_out valid
- rx_data_out  in  8  received byte
- tx_busy  in  1  uart_core transmitter busy
- tx_start_transmission  out  1  one-cycle transmit start pulse
- tx_data_in  out  8  byte to transmit; held stable from the pulse until tx_busy falls
- mem_req  out  1  memory request, level
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  16  byte address
- mem_wdata  out  8  write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle for reads
- mem_rdata  in  8  read data
- busy  out  1  high whenever state is not IDLE
- frame_error  out  1  one-cycle pulse on timeout
- overrun  out  1  sticky; set when a byte is dropped, cleared on the next accepted SYNC_BYTE

Behaviour:
- Reset (asynchronous): state = IDLE; tx_start_transmission, mem_req, mem_we, busy, frame_error and overrun = 0; mem_addr, mem_wdata and tx_data_in = 0.
- Frame format: SYNC, CMD, ADDR_H, ADDR_L, LEN, then LEN data bytes for writes only.
  - CMD 8'h01 = write, 8'h02 = read.
  - LEN 0 means 256.
- IDLE: on rx_done_tick with byte == SYNC_BYTE -> GET_CMD. Any other byte is ignored.
- GET_CMD -> GET_ADDR_H -> GET_ADDR_L -> GET_LEN: each state advances on rx_done_tick and latches the byte.
- Invalid CMD: go to SEND with tx_data_in = NAK_BYTE, then IDLE. ADDR and LEN bytes are not awaited.
- Length counter: 9 bits, loaded with {LEN==0, LEN}.
- Write path:
  - WR_RX waits for rx_done_tick, latches the byte into mem_wdata, asserts mem_req = 1 and mem_we = 1 -> WR_MEM.
  - WR_MEM holds mem_req until mem_ack. On the ack cycle: mem_req = 0, address += 1, count -= 1.
  - If count was 1 -> SEND(ACK_BYTE); otherwise -> WR_RX.
- Read path:
  - RD_MEM asserts mem_req = 1, mem_we = 0.
  - On mem_ack: latch mem_rdata into tx_data_in -> SEND.
  - After the byte completes: address += 1, count -= 1; if count reaches 0 -> IDLE, else -> RD_MEM.
- SEND: when tx_busy == 0, pulse tx_start_transmission for one cycle -> TX_WAIT.
- TX_WAIT: ignores tx_busy for 2 cycles after the pulse, then waits for tx_busy == 0 and returns to the calling path.
- Address arithmetic wraps modulo 2^16 (16'hFFFF + 1 = 16'h0000).
- Timeout:
  - A 32-bit counter clears on every rx_done_tick and on entry to any state that waits for a received byte.
  - It counts only in GET_* and WR_RX.
  - Reaching TIMEOUT_CYCLES: frame_error pulse, -> IDLE, no response sent, mem_req already 0.
- Dropped bytes: rx_done_tick in WR_MEM, RD_MEM, SEND or TX_WAIT discards the byte and sets overrun. The frame continues.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req is high. mem_req never deasserts before mem_ack except on reset.
- Reset mid-frame aborts immediately; no partial response is transmitted afterwards.

Decomposition:
- Shared package/header uart_frame_defs: state encodings, CMD_WRITE = 8'h01, CMD_READ = 8'h02, default SYNC/ACK/NAK values.
- One sub-module: uart_frame_timeout (resettable interval counter with clear/enable inputs and an expired output), reusable by other UART-facing blocks.
- The FSM and datapath stay in uart_frame_controller.

Test Plan:
- Write: A5 01 12 34 02 AA BB, mem_ack 3 cycles after each req -> mem writes (0x1234, AA) and (0x1235, BB); then tx_data_in = 06 with one tx_start pulse; busy low after TX.
- Read: A5 02 FF FF 02, memory returns 5A then C3 -> reads at 0xFFFF then 0x0000 (wrap); transmits 5A then C3, each start pulse issued only when tx_busy == 0.
- Bad command: A5 07 -> one NAK (15) transmitted; no mem_req; the next A5 is accepted as a new frame.
- LEN = 0 write -> exactly 256 mem writes, then ACK; the length counter does not underflow.
- Timeout: A5 01 12, then silence for TIMEOUT_CYCLES -> frame_error pulse once, state IDLE, nothing transmitted.
- Async reset asserted while mem_req = 1 in WR_MEM -> mem_req, busy and tx_start drop immediately; a fresh frame after reset completes normally. Separately, a byte injected during TX_WAIT sets overrun, which clears on the next SYNC.
